s_port_byte_rx: RTL

S_PORT_BYTE_RX -- requirements
Module: s_port_byte_rx

---
 rtl/s_port_pkg.sv | 26 ++
 rtl/s_port_baud_gen.sv | 63 ++++++
 rtl/s_port_byte_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/s_port_pkg.sv
// s_port_pkg: shared types and constants for the serial byte receiver.
//   state_e      - receiver FSM states
//   PAR_*        - parity_mode encodings (2'b11 behaves as PAR_NONE)
//   MIN_DIV      - smallest bit-period divisor the receiver will use
//   par_enabled  - true when a parity bit is expected in the frame
package s_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MIN_DIV = 4;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/s_port_baud_gen.sv
// s_port_baud_gen: bit-period counter, divisor latch/clamp and sample strobe.
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   clr          - hold the period counter at zero (receiver idle)
//   load         - capture baud_div (clamped to MIN_DIV) at frame start
//   baud_div     - requested clk cycles per bit
//   sample_c     - combinational strobe at the bit decision point
// Build option S_PORT_RX_MAJORITY_EN moves the decision point one cycle
// later (half+1) so three samples around the bit centre are available.
module s_port_baud_gen
  import s_port_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] baud_div,
  output logic             sample_c
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] samp_pt;

  // Divisor latch and wrapping period counter
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q + DIV_W'(1);
    if (load) begin
      div_d = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == div_q - DIV_W'(1)) begin
      cnt_d = '0;
    end
  end

  // Decision point relative to the bit start
  always_comb begin
`ifdef S_PORT_RX_MAJORITY_EN
    samp_pt = (div_q >> 1) + DIV_W'(1);
`else
    samp_pt = div_q >> 1;
`endif
  end

  // Counter idles at zero, so this never fires while the receiver is idle
  assign sample_c = (cnt_q == samp_pt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= DIV_W'(MIN_DIV);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/s_port_byte_rx.sv
// s_port_byte_rx: asynchronous serial receiver (start, DATA_BITS LSB-first,
// optional parity, one stop bit).
// Ports:
//   clk          - clock, all logic on rising edge
//   reset        - synchronous active-low reset
//   s_in         - asynchronous serial line, idle high
//   baud_div     - clk cycles per bit, latched at frame start (min 4)
//   parity_mode  - 00 none, 01 even, 10 odd, 11 none; latched at frame start
//   data_out     - received word, held until next data_valid
//   data_valid   - one-cycle pulse after the stop-bit decision
//   parity_err   - parity mismatch for data_out (0 when parity is none)
//   frame_err    - stop bit sampled low
//   busy         - receiver not idle
// Build option S_PORT_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// samples at half-1, half and half+1, decided at half+1.
module s_port_byte_rx
  import s_port_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_in,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  state_e                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   prev_q, prev_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             par_mode_q, par_mode_d;
  logic                   par_acc_q, par_acc_d;
  logic                   par_err_q, par_err_d;
  logic                   fall_pend_q, fall_pend_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  logic                   fall_c;
  logic                   bit_c;
  logic                   sample_c;
  logic                   load_c;
  logic                   clr_c;

`ifdef S_PORT_RX_MAJORITY_EN
  logic                   prev2_q, prev2_d;
  assign prev2_d = prev_q;
  // sync2_q, prev_q, prev2_q hold the samples at half+1, half, half-1
  assign bit_c = (prev2_q & prev_q) | (prev2_q & sync2_q) | (prev_q & sync2_q);
`else
  assign bit_c = sync2_q;
`endif

  assign fall_c = prev_q & ~sync2_q;

  // Counter is held at zero whenever the FSM is, or is about to be, idle
  assign clr_c = (state_q == ST_IDLE) || (state_d == ST_IDLE);

  s_port_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_c),
    .load     (load_c),
    .baud_div (baud_div),
    .sample_c (sample_c)
  );

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    sync1_d      = s_in;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_mode_d   = par_mode_q;
    par_acc_d    = par_acc_q;
    par_err_d    = par_err_q;
    fall_pend_d  = fall_pend_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    load_c       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        fall_pend_d = 1'b0;
        if (fall_c || fall_pend_q) begin
          state_d    = ST_START;
          load_c     = 1'b1;
          par_mode_d = parity_mode;
        end
      end
      ST_START: begin
        if (sample_c) begin
          if (bit_c) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            idx_d     = '0;
            par_acc_d = 1'b0;
            par_err_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample_c) begin
          shift_d   = {bit_c, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ bit_c;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = par_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample_c) begin
          par_err_d = (par_mode_q == PAR_EVEN) ? (par_acc_q ^ bit_c)
                                               : ~(par_acc_q ^ bit_c);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_c) begin
          state_d      = ST_IDLE;
          data_valid_d = 1'b1;
          data_out_d   = shift_q;
          parity_err_d = par_err_q;
          frame_err_d  = ~bit_c;
          // An edge coinciding with the stop decision would be lost otherwise
          fall_pend_d  = fall_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      idx_q        <= '0;
      shift_q      <= '0;
      par_mode_q   <= PAR_NONE;
      par_acc_q    <= 1'b0;
      par_err_q    <= 1'b0;
      fall_pend_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_mode_q   <= par_mode_d;
      par_acc_q    <= par_acc_d;
      par_err_q    <= par_err_d;
      fall_pend_q  <= fall_pend_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef S_PORT_RX_MAJORITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev2_q <= 1'b1;
    end else begin
      prev2_q <= prev2_d;
    end
  end
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
